// File: rtl/idex_reg_pkg.sv
// idex_reg_pkg: shared processor definitions for decode, ID/EX register and EX.
package idex_reg_pkg;
    localparam int DW_DEF = 32;
    localparam int CTRL_W = 9;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_IMM   = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   reg_dst;
        logic   alu_src;
        logic   mem_to_reg;
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   branch;
        aluop_e alu_op;
    } ctrl_t;
endpackage

// File: rtl/idex_reg_if.sv
// idex_reg_if: ID-side inputs, EX-side outputs and hazard feedback of the ID/EX register.
interface idex_reg_if import idex_reg_pkg::*; #(parameter int DW = DW_DEF, parameter int CW = 16);
    logic          HazardMux, flush;
    logic          ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_Branch;
    logic [1:0]    ID_ALUOp;
    logic [4:0]    ID_rs, ID_rt, ID_rd;
    logic [DW-1:0] ID_rdata1, ID_rdata2, ID_signext, ID_pc4;
    logic          EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch;
    logic [1:0]    EX_ALUOp;
    logic [4:0]    EX_rs, EX_rt, EX_rd;
    logic [DW-1:0] EX_rdata1, EX_rdata2, EX_signext, EX_pc4;
    logic [4:0]    IDEX_rt;
    logic          memread, bubble_q;
    logic [CW-1:0] bubble_count;

    modport master (
        output HazardMux, flush, ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite, ID_MemRead,
               ID_MemWrite, ID_Branch, ID_ALUOp, ID_rs, ID_rt, ID_rd, ID_rdata1, ID_rdata2,
               ID_signext, ID_pc4,
        input  EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch,
               EX_ALUOp, EX_rs, EX_rt, EX_rd, EX_rdata1, EX_rdata2, EX_signext, EX_pc4,
               IDEX_rt, memread, bubble_q, bubble_count
    );
    modport slave (
        input  HazardMux, flush, ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite, ID_MemRead,
               ID_MemWrite, ID_Branch, ID_ALUOp, ID_rs, ID_rt, ID_rd, ID_rdata1, ID_rdata2,
               ID_signext, ID_pc4,
        output EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Branch,
               EX_ALUOp, EX_rs, EX_rt, EX_rd, EX_rdata1, EX_rdata2, EX_signext, EX_pc4,
               IDEX_rt, memread, bubble_q, bubble_count
    );
endinterface

// File: rtl/idex_reg_sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(parameter int CW = 16) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] count
);
    logic [CW-1:0] count_d, count_q;

    always_comb count_d = (inc && count_q != '1) ? count_q + CW'(1) : count_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) count_q <= '0;
        else count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/idex_reg.sv
// idex_reg: ID/EX pipeline register; a stall or flush zeroes only the control bundle.
module idex_reg import idex_reg_pkg::*; #(parameter int DW = DW_DEF, parameter int CW = 16) (
    input logic       clk,
    input logic       reset,
    idex_reg_if.slave bus
);
    logic          bubble_d, bubble_q;
    ctrl_t         ctrl_d, ctrl_q;
    logic [4:0]    rs_q, rt_q, rd_q;
    logic [DW-1:0] rdata1_q, rdata2_q, signext_q, pc4_q;

    assign bubble_d = bus.HazardMux | bus.flush;

    always_comb ctrl_d = bubble_d ? '0 : ctrl_t'({bus.ID_RegDst, bus.ID_ALUSrc, bus.ID_MemtoReg,
        bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite, bus.ID_Branch, bus.ID_ALUOp});

    // Operands keep flowing through a bubble; only control is squashed.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bubble_q  <= 1'b0;
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
            signext_q <= '0;
            pc4_q     <= '0;
        end else begin
            bubble_q  <= bubble_d;
            ctrl_q    <= ctrl_d;
            rs_q      <= bus.ID_rs;
            rt_q      <= bus.ID_rt;
            rd_q      <= bus.ID_rd;
            rdata1_q  <= bus.ID_rdata1;
            rdata2_q  <= bus.ID_rdata2;
            signext_q <= bus.ID_signext;
            pc4_q     <= bus.ID_pc4;
        end

    sat_counter #(.CW(CW)) u_cnt (.clk(clk), .reset(reset), .inc(bubble_d), .count(bus.bubble_count));

    assign {bus.EX_RegDst, bus.EX_ALUSrc, bus.EX_MemtoReg, bus.EX_RegWrite, bus.EX_MemRead,
            bus.EX_MemWrite, bus.EX_Branch, bus.EX_ALUOp} = ctrl_q;
    assign bus.EX_rs      = rs_q;
    assign bus.EX_rt      = rt_q;
    assign bus.EX_rd      = rd_q;
    assign bus.EX_rdata1  = rdata1_q;
    assign bus.EX_rdata2  = rdata2_q;
    assign bus.EX_signext = signext_q;
    assign bus.EX_pc4     = pc4_q;
    assign bus.IDEX_rt    = rt_q;
    assign bus.memread    = ctrl_q.mem_read;
    assign bus.bubble_q   = bubble_q;
endmodule

// File: doc/idex_reg.md
IDEX_REG -- requirements
Module: idex_reg

Interface
REQ-001 Parameter DW, default 32, datapath word width.
REQ-002 Parameter CW, default 16, bubble-counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 HazardMux  input  1  load-use stall from the hazard unit; 1 = insert a bubble this cycle.
REQ-006 flush  input  1  control-hazard squash (taken branch); 1 = insert a bubble this cycle.
REQ-007 ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_Branch  input  1 each  decoded control from ID.
REQ-008 ID_ALUOp  input  2  ALU operation class from ID.
REQ-009 ID_rs, ID_rt, ID_rd  input  5 each  register specifiers from IF/ID.
REQ-010 ID_rdata1, ID_rdata2, ID_signext, ID_pc4  input  DW each  register-file reads, sign-extended immediate, PC+4.
REQ-011 EX_* (one per ID_* input above)  output  same width  registered copies presented to EX.
REQ-012 IDEX_rt  output  5  alias of EX_rt, returned to the hazard unit.
REQ-013 memread  output  1  alias of EX_MemRead, returned to the hazard unit.
REQ-014 bubble_count  output  CW  saturating count of bubbles inserted since reset.
REQ-015 bubble_q  output  1  1 when the current EX contents are a bubble.

Function
REQ-016 Latency SHALL be exactly one clock: ID_* sampled at edge N appear on EX_* after edge N.
REQ-017 Register is never held; a new value SHALL be captured every cycle (stall of IF/ID and PC is outside this block).
REQ-018 Bubble condition B = HazardMux OR flush.
REQ-019 When B=1, all nine control outputs (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp) SHALL be captured as 0.
REQ-020 When B=1, rs/rt/rd, rdata1/2, signext, pc4 SHALL still be captured from ID (bubble is control-only).
REQ-021 When B=0, every EX_* SHALL equal the sampled ID_* value.
REQ-022 bubble_q SHALL be registered B.
REQ-023 HazardMux and flush asserted together SHALL count as one bubble.
REQ-024 bubble_count SHALL increment by 1 on each edge with B=1, and SHALL hold at 2^CW-1 (no wrap).
REQ-025 Because IDEX_rt and memread are registered, a load followed by a dependent instruction SHALL yield memread=1 and IDEX_rt=load rt in the cycle the dependent sits in IF/ID.
REQ-026 After a bubble, memread SHALL be 0 the next cycle, so the hazard unit releases the stall after exactly one bubble.

Reset
REQ-027 On reset=1, all EX_* outputs, bubble_q and bubble_count SHALL go to 0 immediately, without waiting for clk.
REQ-028 While reset=1, HazardMux/flush SHALL be ignored and bubble_count SHALL not increment.
REQ-029 On the first edge after reset deasserts, normal capture per REQ-016..024 SHALL resume.
REQ-030 Reset asserted mid-stall SHALL clear the state; no pending bubble survives reset.

Structure
REQ-031 Control-bundle width (9 bits), ALUOp encodings and DW default SHALL live in the shared processor package used by decode and EX.
REQ-032 The saturating counter SHALL be a sub-module named sat_counter (parameter CW, inputs clk, reset, inc; output count).
REQ-033 No other sub-modules; datapath flops SHALL be a single registered block.

Verification
REQ-034 Reset pulse mid-run with EX_RegWrite=1, bubble_count=5 -> all outputs 0 before next clk edge.
REQ-035 ID_MemRead=1, ID_rt=8, HazardMux=0 for one cycle -> next cycle memread=1, IDEX_rt=8, bubble_q=0.
REQ-036 HazardMux=1 with ID_RegWrite=1, ID_rd=9, ID_rdata1=0x12345678 -> EX_RegWrite=0, EX_rd=9, EX_rdata1=0x12345678, bubble_q=1, bubble_count +1.
REQ-037 HazardMux=1 and flush=1 same cycle -> one bubble, bubble_count increments by exactly 1.
REQ-038 CW=4, 20 consecutive bubbles -> bubble_count reaches 15 and holds 15.
REQ-039 Random ID stream with B=0 for 100 cycles -> every EX_* equals prior-cycle ID_*, bubble_count unchanged.
